// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter steering a shared 2:1 data mux
// into a registered valid/ready output stage with bounded bursts.
module mux2_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
);

  localparam int BW_RAW = $clog2(MAX_BURST + 1);
  localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;

  logic             can_load;
  logic             xfer0, xfer1;
  logic             cur_k;
  logic             cur_valid, oth_valid;
  logic [BW-1:0]    burst_inc;
  state_e           oth_state;

  always_comb begin
    can_load  = !out_valid_q || out_ready;
    in0_ready = (state_q == GRANT0) && can_load;
    in1_ready = (state_q == GRANT1) && can_load;
    xfer0     = in0_valid && in0_ready;
    xfer1     = in1_valid && in1_ready;
    cur_k     = (state_q == GRANT1);
    cur_valid = cur_k ? in1_valid : in0_valid;
    oth_valid = cur_k ? in0_valid : in1_valid;
    oth_state = cur_k ? GRANT0 : GRANT1;
    burst_inc = (burst_q == BMAX) ? BMAX
                                  : burst_q + BW'(1);
  end

  // output register: load on transfer, drain when consumer frees it
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_sel_d   = 1'b0;
    end else if (xfer1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_sel_d   = 1'b1;
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        if (in0_valid && in1_valid)
          state_d = ptr_q ? GRANT1 : GRANT0;
        else if (in0_valid)
          state_d = GRANT0;
        else if (in1_valid)
          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!cur_valid) begin
          // release hands over without an idle bubble
          ptr_d   = !cur_k;
          burst_d = '0;
          state_d = oth_valid ? oth_state : IDLE;
        end else if (xfer0 || xfer1) begin
          burst_d = burst_inc;
          if (burst_inc == BMAX && oth_valid) begin
            ptr_d   = !cur_k;
            burst_d = '0;
            state_d = oth_state;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: vector table, directed
// corner sequences and random traffic against a grant-owner model.
module tb_mux2_arbiter;

  localparam int W  = 32;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in0_valid, in1_valid;
  logic         in0_ready, in1_ready;
  logic [W-1:0] in0_data, in1_data;
  logic         out_valid, out_ready, out_sel;
  logic [W-1:0] out_data;

  int total = 0;
  int bad   = 0;

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in0_data (in0_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .in1_data (in1_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  always #5 clk = ~clk;

  // owner: -1 nobody granted, else index of granted requester
  int          m_own;
  int          m_ptr;
  int          m_run;
  logic        m_ov;
  logic [31:0] m_od;
  logic        m_os;
  logic        m_x [2];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = 0;
    m_run = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 1'b0;
    m_x[0] = 1'b0;
    m_x[1] = 1'b0;
  endtask

  task automatic model_check();
    logic can;
    can = !m_ov || out_ready;
    check("m_in0_ready", {31'd0, in0_ready}, {31'd0, (m_own == 0) && can});
    check("m_in1_ready", {31'd0, in1_ready}, {31'd0, (m_own == 1) && can});
    check("m_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("m_out_sel", {31'd0, out_sel}, {31'd0, m_os});
    check("m_out_data", out_data, m_od);
  endtask

  // advance one clock; the model follows the grant rules directly
  task automatic tick();
    logic        vv [2];
    logic [31:0] dd [2];
    logic        can;
    int          o;
    @(posedge clk);
    vv[0] = in0_valid;
    vv[1] = in1_valid;
    dd[0] = in0_data;
    dd[1] = in1_data;
    can = !m_ov || out_ready;
    m_x[0] = 1'b0;
    m_x[1] = 1'b0;
    if (m_own >= 0 && vv[m_own] && can) m_x[m_own] = 1'b1;
    if (m_own >= 0 && m_x[m_own]) begin
      m_ov = 1'b1;
      m_od = dd[m_own];
      m_os = m_own[0];
    end else if (can) begin
      m_ov = 1'b0;
    end
    if (m_own < 0) begin
      m_run = 0;
      if (vv[0] && vv[1]) m_own = m_ptr;
      else if (vv[0]) m_own = 0;
      else if (vv[1]) m_own = 1;
    end else begin
      o = 1 - m_own;
      if (!vv[m_own]) begin
        m_ptr = o;
        m_run = 0;
        m_own = vv[o] ? o : -1;
      end else if (m_x[m_own]) begin
        m_run = (m_run + 1 > MB) ? MB : m_run + 1;
        if (m_run == MB && vv[o]) begin
          m_own = o;
          m_run = 0;
          m_ptr = o;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    if (m_x[0]) in0_data = in0_data + 1;
    if (m_x[1]) in1_data = in1_data + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        v0, v1, ordy;
    logic [31:0] d0, d1;
    logic        r0, r1, ov, os;
    logic [31:0] od;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'hA0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'hA0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'hA1, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'hA2, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'hA3, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'hA4, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA3};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'hA5, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA4};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'hA5, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'hA5};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'hA5, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hA5};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h0,  32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'hB0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB1};

    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h11;
    in1_data  = 32'h22;
    out_ready = 1'b1;
    model_reset();

    // reset held with both requesters valid
    @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    check("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sel", {31'd0, out_sel}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    settle();
    check("rel_idle_in0_ready", {31'd0, in0_ready}, 32'd0);
    tick();
    settle();
    check("rel_g0_in0_ready", {31'd0, in0_ready}, 32'd1);
    check("rel_g0_in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();

    // vector table: single streaming requester, stall, release
    do_reset();
    for (int i = 0; i < 15; i++) begin
      in0_valid = tbl[i].v0;
      in1_valid = tbl[i].v1;
      out_ready = tbl[i].ordy;
      in0_data  = tbl[i].d0;
      in1_data  = tbl[i].d1;
      #1;
      check($sformatf("tbl%0d_in0_ready", i), {31'd0, in0_ready}, {31'd0, tbl[i].r0});
      check($sformatf("tbl%0d_in1_ready", i), {31'd0, in1_ready}, {31'd0, tbl[i].r1});
      check($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("tbl%0d_out_sel", i), {31'd0, out_sel}, {31'd0, tbl[i].os});
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].od);
      model_check();
      tick();
    end

    // fair bursts: both valid forever
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h100;
    in1_data  = 32'h200;
    out_ready = 1'b1;
    settle();
    tick();
    settle();
    tick();
    advance();
    for (int i = 0; i < 12; i++) begin
      settle();
      check($sformatf("fair%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("fair%0d_out_sel", i), {31'd0, out_sel}, (i / 4) % 2);
      tick();
      advance();
    end

    // backpressure in GRANT1; burst count survives the stall
    do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'hDEAD;
    out_ready = 1'b1;
    settle();
    tick();
    settle();
    tick();
    in1_data  = 32'hBEEF;
    in0_valid = 1'b1;
    in0_data  = 32'h111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bp%0d_out_data", i), out_data, 32'hDEAD);
      check($sformatf("bp%0d_in1_ready", i), {31'd0, in1_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    settle();
    check("bp_resume_in1_ready", {31'd0, in1_ready}, 32'd1);
    tick();
    in1_data = 32'hC1;
    settle();
    check("bp_beef_loaded", out_data, 32'hBEEF);
    tick();
    in1_data = 32'hC2;
    settle();
    tick();
    in1_data = 32'hC3;
    settle();
    check("bp_switch_in0_ready", {31'd0, in0_ready}, 32'd1);
    check("bp_switch_in1_ready", {31'd0, in1_ready}, 32'd0);
    check("bp_last_data", out_data, 32'hC2);
    tick();

    // early release hands grant to the waiting side
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h300;
    in1_data  = 32'h400;
    out_ready = 1'b1;
    settle();
    tick();
    settle();
    tick();
    advance();
    settle();
    tick();
    advance();
    in0_valid = 1'b0;
    settle();
    check("er_drop_in1_ready", {31'd0, in1_ready}, 32'd0);
    tick();
    settle();
    check("er_g1_in1_ready", {31'd0, in1_ready}, 32'd1);
    check("er_g1_in0_ready", {31'd0, in0_ready}, 32'd0);
    tick();
    in1_valid = 1'b0;
    settle();
    check("er_drain_out_valid", {31'd0, out_valid}, 32'd1);
    check("er_drain_out_data", out_data, 32'h400);
    tick();
    settle();
    check("er_idle_out_valid", {31'd0, out_valid}, 32'd0);
    tick();

    // asynchronous reset between edges while GRANT1 holds a beat
    do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'h55;
    out_ready = 1'b0;
    settle();
    tick();
    settle();
    tick();
    #2;
    check("ar_pre_out_sel", {31'd0, out_sel}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_in1_ready", {31'd0, in1_ready}, 32'd0);
    check("ar_out_sel", {31'd0, out_sel}, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    in0_valid = 1'b1;
    out_ready = 1'b1;
    settle();
    tick();
    settle();
    check("ar_restart_in0_ready", {31'd0, in0_ready}, 32'd1);
    tick();

    // random traffic obeying the valid/ready holding rules
    do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!in0_valid || m_x[0]) begin
        in0_valid = (i < 400) ? ($urandom_range(0, 3) != 0)
                              : ($urandom_range(0, 3) == 0);
        in0_data  = $urandom;
      end
      if (!in1_valid || m_x[1]) begin
        in1_valid = ($urandom_range(0, 2) != 0);
        in1_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
